// File: rtl/multdiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Imported by the FSM top and its datapath.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/multdiv_datapath.sv
// Magnitude shift-add multiply / restoring divide, one bit per i_step; result and exception
// are registered on the i_last step and held until the next completion.
module multdiv_datapath
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_step,
    input  logic             i_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_exception
);

    localparam int W = WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;
    logic           r_op;
    logic           r_neg;
    logic           r_div0;
    logic           r_ovf;
    logic [W-1:0]   r_result;
    logic           r_exception;

    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W:0]     w_sum;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_trial;
    logic           w_fits;
    logic [2*W-1:0] w_acc_nxt;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;

    assign w_mag_a = i_a[W-1] ? -i_a : i_a;
    assign w_mag_b = i_b[W-1] ? -i_b : i_b;

    // Multiply: add multiplicand into the high half when the LSB is set, then shift right.
    assign w_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opnd : {W{1'b0}})};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign w_rem_sh = r_acc[2*W-1:W-1];
    assign w_trial  = w_rem_sh - {1'b0, r_opnd};
    assign w_fits   = ~w_trial[W];

    assign w_acc_nxt = (r_op == OP_MULT)
        ? {w_sum, r_acc[W-1:1]}
        : {(w_fits ? w_trial[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_fits};

    assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = r_neg ? -w_acc_nxt[W-1:0] : w_acc_nxt[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_opnd      <= '0;
            r_op        <= OP_MULT;
            r_neg       <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else if (i_load) begin
            r_op   <= i_op;
            r_opnd <= (i_op == OP_MULT) ? w_mag_a : w_mag_b;
            r_acc  <= {{W{1'b0}}, ((i_op == OP_MULT) ? w_mag_b : w_mag_a)};
            r_neg  <= i_a[W-1] ^ i_b[W-1];
            r_div0 <= (i_b == {W{1'b0}});
            r_ovf  <= (i_a == MIN_VAL) && (i_b == {W{1'b1}});
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            if (i_last) begin
                if (r_op == OP_MULT) begin
                    r_result    <= w_prod[W-1:0];
                    r_exception <= (w_prod[2*W-1:W] != {W{w_prod[W-1]}});
                end else if (r_div0) begin
                    r_result    <= '0;
                    r_exception <= 1'b1;
                end else if (r_ovf) begin
                    r_result    <= MIN_VAL;
                    r_exception <= 1'b1;
                end else begin
                    r_result    <= w_quo;
                    r_exception <= 1'b0;
                end
            end
        end
    end

    assign o_result    = r_result;
    assign o_exception = r_exception;

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit multiply/divide responder: issue pulse -> busy for ITERS edges -> one-cycle
// data_resultRDY; pulses while busy are dropped, so the pipeline must stall on busy.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = multdiv_pkg::ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       dest_in,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [4:0]       dest_out,
    output logic             busy
);

    localparam int CW = $clog2(ITERS + 1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic          r_rdy;
    logic [4:0]    r_dest;

    logic          w_issue;
    op_t           w_op;
    logic          w_step;
    logic          w_last;

    assign w_issue = (ctrl_MULT | ctrl_DIV) && (r_state != RUN);
    assign w_op    = ctrl_MULT ? OP_MULT : OP_DIV;
    assign w_step  = (r_state == RUN);
    assign w_last  = w_step && (r_count == CW'(ITERS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
            r_dest  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_rdy <= 1'b0;
                    if (w_issue) begin
                        r_state <= RUN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_dest  <= dest_in;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clock),
        .rst         (reset),
        .i_load      (w_issue),
        .i_op        (w_op),
        .i_a         (data_operandA),
        .i_b         (data_operandB),
        .i_step      (w_step),
        .i_last      (w_last),
        .o_result    (data_result),
        .o_exception (data_exception)
    );

    assign busy           = r_busy;
    assign data_resultRDY = r_rdy;
    assign dest_out       = r_dest;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: a behavioural model queues expected results and strobe
// edges at issue; a negedge monitor checks busy/strobe timing and pops results.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  dest_in = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [4:0]  dest_out;
    logic        busy;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .dest_in        (dest_in),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .dest_out       (dest_out),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  dest;
        int          start;
        int          done;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] d);
        exp_t e;
        logic signed [63:0] p;
        int sa;
        int sb;
        e.dest  = d;
        e.start = 0;
        e.done  = 0;
        if (is_mult) begin
            p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e.res = p[31:0];
            e.exc = (p[63:32] != {32{p[31]}});
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            e.res = INT_MIN;
            e.exc = 1'b1;
        end else begin
            sa    = $signed(a);
            sb    = $signed(b);
            e.res = 32'(sa / sb);
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Call at a negedge; the pulse is sampled at the next posedge.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst);
        exp_t e;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        dest_in       = dst;
        if (q.size() == 0 || cyc + 1 > q[$].done) begin
            e       = model(m, a, b, dst);
            e.start = cyc + 1;
            e.done  = cyc + 1 + ITERS;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        dest_in       = 5'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clock);
        if (q.size() != 0) begin
            check_eq("timeout_idle", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clock);
    endtask

    task automatic wait_strobe_cycle();
        int target;
        target = q[$].done;
        for (int k = 0; k < 100 && cyc != target; k++) @(negedge clock);
        if (cyc != target) check_eq("timeout_strobe", 64'(cyc), 64'(target));
    endtask

    always @(negedge clock) begin : mon
        logic eb;
        logic er;
        eb = (q.size() > 0) && (cyc >= q[0].start) && (cyc < q[0].done);
        er = (q.size() > 0) && (cyc == q[0].done);
        check_eq("busy", 64'(busy), 64'(eb));
        check_eq("rdy", 64'(data_resultRDY), 64'(er));
        if (eb) check_eq("dest_busy", 64'(dest_out), 64'(q[0].dest));
        if (er) begin
            check_eq("result", 64'(data_result), 64'(q[0].res));
            check_eq("exception", 64'(data_exception), 64'(q[0].exc));
            check_eq("dest_rdy", 64'(dest_out), 64'(q[0].dest));
            void'(q.pop_front());
        end else if (q.size() > 0 && cyc > q[0].done) begin
            void'(q.pop_front());
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        check_eq("rst_result", 64'(data_result), 64'd0);
        check_eq("rst_exc", 64'(data_exception), 64'd0);
        check_eq("rst_rdy", 64'(data_resultRDY), 64'd0);
        check_eq("rst_dest", 64'(dest_out), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        issue(1'b1, 1'b0, 32'd7, -32'sd6, 5'd3);                wait_idle();
        issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 5'd4);          wait_idle();
        issue(1'b1, 1'b0, INT_MIN, 32'd1, 5'd5);                wait_idle();
        issue(1'b0, 1'b1, -32'sd7, 32'd2, 5'd6);                wait_idle();
        issue(1'b0, 1'b1, 32'd5, 32'd0, 5'd7);                  wait_idle();

        // Overflowing divide, then a new multiply issued in its DONE cycle.
        issue(1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF, 5'd8);
        wait_strobe_cycle();
        issue(1'b1, 1'b0, -32'sd3, -32'sd9, 5'd9);              wait_idle();

        // Pulse during RUN must be ignored.
        issue(1'b1, 1'b0, 32'd100, -32'sd3, 5'd10);
        repeat (5) @(negedge clock);
        issue(1'b0, 1'b1, 32'd77, 32'd5, 5'd11);                wait_idle();

        // Both pulses together: multiply wins.
        issue(1'b1, 1'b1, 32'd12, -32'sd12, 5'd12);             wait_idle();

        // Reset at E10 of a divide: outputs clear at once and no strobe follows.
        issue(1'b0, 1'b1, 32'd1000, 32'd7, 5'd13);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        q.delete();
        #1;
        check_eq("midrst_result", 64'(data_result), 64'd0);
        check_eq("midrst_exc", 64'(data_exception), 64'd0);
        check_eq("midrst_rdy", 64'(data_resultRDY), 64'd0);
        check_eq("midrst_dest", 64'(dest_out), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        issue(1'b0, 1'b1, -32'sd1000, 32'd7, 5'd14);            wait_idle();

        for (int i = 0; i < 8; i++) begin
            issue(i[0], ~i[0], $urandom, (i == 5) ? 32'd3 : $urandom, 5'(i + 16));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
